nand3_vector_sequencer: RTL and testbench
=========================================

// Module: nand3_vector_sequencer
// PURPOSE
//  Self-checking stimulus controller for a 3-input NAND DUT with two redundant outputs (d, e).
//  On start, walks all 8 input vectors {a,b,c}=000..111 (a slowest, c fastest), waits a settle time,
//  samples d/e, compares against ~(a&b&c), counts mismatches and reports pass/fail.
//  Sits beside the gate in lab top-levels/benches; replaces free-running toggle stimulus with sequenced checks.
// PARAMETERS
//  SETTLE_CYCLES  4  cycles between driving a vector and sampling d/e, minus 1 (0 = sample next-but-one cycle)
//  ERR_W          4  width of err_count (must hold 8)
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      begin a sweep; sampled only in IDLE or DONE
//  a          out  1      DUT input a (vector bit 2)
//  b          out  1      DUT input b (vector bit 1)
//  c          out  1      DUT input c (vector bit 0)
//  d          in   1      DUT output, first NAND realisation
//  e          in   1      DUT output, second NAND realisation
//  busy       out  1      sweep in progress
//  done       out  1      sweep finished; held until next accepted start or rst
//  pass       out  1      valid when done: 1 iff err_count==0
//  err_count  out  ERR_W  number of failing vectors in current/last sweep
//  vec_idx    out  3      vector currently applied ({a,b,c})
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state IDLE; a=b=c=0, busy=0, done=0, pass=0, err_count=0, vec_idx=0, settle cnt=0.
//  - States: IDLE, SETTLE, CHECK, DONE. All outputs registered.
//  - IDLE/DONE + start=1: vec_idx<=0 ({a,b,c}<=000), err_count<=0, done<=0, pass<=0, busy<=1, cnt<=SETTLE_CYCLES -> SETTLE.
//  - SETTLE: cnt==0 -> CHECK, else cnt<=cnt-1. Inputs a/b/c held stable.
//  - CHECK: exp=~(a&b&c). If d!=exp or e!=exp: err_count<=err_count+1 (one count per vector even if both wrong).
//    vec_idx==7 -> DONE: busy<=0, done<=1, pass<=(final err_count==0). Else vec_idx<=vec_idx+1, cnt<=SETTLE_CYCLES -> SETTLE.
//  - Per vector SETTLE_CYCLES+2 cycles; done=1 exactly 8*(SETTLE_CYCLES+2) posedges after the edge sampling start (default 48).
//  - start while busy (SETTLE/CHECK): ignored, no effect on sweep.
//  - DONE: a/b/c hold last vector (111); start re-arms from 000.
//  - rst mid-sweep: immediate return to reset values at that edge; no partial result retained; rst beats start.
//  - err_count max 8 <= 2^ERR_W-1; no wrap possible at default.
// CONFIGURATION
//  NAND3_SEQ_STOP_ON_ERR_EN defined: in CHECK, first mismatch -> DONE directly (err_count=1, pass=0,
//    vec_idx and a/b/c hold the failing vector). Undefined: always completes all 8 vectors.
// STRUCTURE
//  - nand3_seq_pkg: state encodings (IDLE/SETTLE/CHECK/DONE), VEC_LAST=3'd7, nand3_exp function.
//  - Sub-module nand3_ref: combinational golden model, in {a,b,c} -> out exp; instanced once.
//  - Rest (FSM, settle counter, vector counter, error counter) in this module.
// TESTING
//  1. rst 2 cycles, correct DUT, start pulse -> vec_idx 0..7 in order, done=1 at cycle 48, pass=1, err_count=0.
//  2. DUT e stuck-1 -> only vector 111 fails -> err_count=1, pass=0, done at cycle 48.
//  3. DUT d stuck-0 -> err_count=7 (000..110 fail); with NAND3_SEQ_STOP_ON_ERR_EN: done at cycle 6, err_count=1, vec_idx=0.
//  4. start re-pulsed at cycle 10 of sweep -> ignored; sequence/timing identical to test 1.
//  5. rst at cycle 20 mid-sweep -> next cycle busy=0, a=b=c=0, err_count=0; new start gives full clean sweep.
//  6. SETTLE_CYCLES=0 -> 2 cycles/vector, done at cycle 16, pass=1; start in DONE restarts from 000 with done cleared.

Source files
------------

// File: rtl/nand3_seq_pkg.sv
// Shared definitions for the NAND3 vector sequencer: FSM states, last
// vector index and the golden NAND3 function.
package nand3_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } seq_state_t;

    localparam logic [2:0] VEC_LAST = 3'd7;

    // Expected NAND3 response for vector {a,b,c}.
    function automatic logic nand3_exp(input logic [2:0] v);
        return ~(&v);
    endfunction

endpackage

// File: rtl/nand3_ref.sv
// Combinational golden model of a 3-input NAND; vec = {a,b,c}.
module nand3_ref
    import nand3_seq_pkg::*;
(
    input  logic [2:0] vec,
    output logic       exp
);

    // Golden response for the applied vector.
    always_comb begin
        exp = nand3_exp(vec);
    end

endmodule

// File: rtl/nand3_vector_sequencer.sv
// Sequenced self-check of a 3-input NAND with two redundant outputs (d, e).
// Walks {a,b,c} = 000..111, waits SETTLE_CYCLES+1 cycles per vector, then
// compares d/e against the golden model and counts failing vectors.
// Optional build macro NAND3_SEQ_STOP_ON_ERR_EN: stop at the first failing
// vector, holding it on a/b/c and vec_idx.
module nand3_vector_sequencer
    import nand3_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             c,
    input  logic             d,
    input  logic             e,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       vec_idx
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);

    seq_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       vec_next;
    logic [ERR_W-1:0] err_next;
    logic             busy_next, done_next, pass_next;

    logic             exp_bit;
    logic             mismatch;
    logic [ERR_W-1:0] err_final;

    nand3_ref u_ref (
        .vec (vec_idx),
        .exp (exp_bit)
    );

    assign a = vec_idx[2];
    assign b = vec_idx[1];
    assign c = vec_idx[0];

    assign mismatch  = (d != exp_bit) || (e != exp_bit);
    assign err_final = mismatch ? err_count + ERR_W'(1) : err_count;

    // State and datapath registers; reset wins over any start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            vec_idx   <= '0;
            err_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            vec_idx   <= vec_next;
            err_count <= err_next;
            busy      <= busy_next;
            done      <= done_next;
            pass      <= pass_next;
        end
    end

    // Next-state and next-output logic for the sweep.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        vec_next   = vec_idx;
        err_next   = err_count;
        busy_next  = busy;
        done_next  = done;
        pass_next  = pass;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    vec_next   = '0;
                    err_next   = '0;
                    done_next  = 1'b0;
                    pass_next  = 1'b0;
                    busy_next  = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) begin
                    state_next = ST_CHECK;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_CHECK: begin
                err_next = err_final;
`ifdef NAND3_SEQ_STOP_ON_ERR_EN
                if (mismatch || vec_idx == VEC_LAST) begin
`else
                if (vec_idx == VEC_LAST) begin
`endif
                    // pass reflects the count including this last check.
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    pass_next  = (err_final == '0);
                    state_next = ST_DONE;
                end else begin
                    vec_next   = vec_idx + 3'd1;
                    cnt_next   = CNT_LOAD;
                    state_next = ST_SETTLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nand3_vector_sequencer.sv
// Directed bench for nand3_vector_sequencer: a modelled NAND3 "DUT" with
// injectable faults feeds d/e; expected vector sequence and sweep results
// are queued when a sweep is started and popped as the sequencer runs.
module tb_nand3_vector_sequencer;

    typedef struct {
        int err;
        int pass;
        int vec;
        int k;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic fault_d0 = 1'b0;
    logic fault_e1 = 1'b0;

    logic a0, b0, c0, d0, e0, busy0, done0, pass0;
    logic [3:0] err0;
    logic [2:0] vec0;
    logic a1, b1, c1, d1, e1, busy1, done1, pass1;
    logic [3:0] err1;
    logic [2:0] vec1;

    logic sel = 1'b0;
    logic o_a, o_b, o_c, o_busy, o_done, o_pass;
    logic [3:0] o_err;
    logic [2:0] o_vec;

    int n_vec  = 0;
    int n_fail = 0;
    int vec_q[$];
    res_t res_q[$];

    always #5 clk = ~clk;

    // Modelled gate under test, with stuck-at faults on each output.
    assign d0 = fault_d0 ? 1'b0 : ~(a0 & b0 & c0);
    assign e0 = fault_e1 ? 1'b1 : ~(a0 & b0 & c0);
    assign d1 = fault_d0 ? 1'b0 : ~(a1 & b1 & c1);
    assign e1 = fault_e1 ? 1'b1 : ~(a1 & b1 & c1);

    assign o_a    = sel ? a1 : a0;
    assign o_b    = sel ? b1 : b0;
    assign o_c    = sel ? c1 : c0;
    assign o_busy = sel ? busy1 : busy0;
    assign o_done = sel ? done1 : done0;
    assign o_pass = sel ? pass1 : pass0;
    assign o_err  = sel ? err1 : err0;
    assign o_vec  = sel ? vec1 : vec0;

    nand3_vector_sequencer #(.SETTLE_CYCLES(4), .ERR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start0),
        .a(a0), .b(b0), .c(c0), .d(d0), .e(e0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .vec_idx(vec0)
    );

    nand3_vector_sequencer #(.SETTLE_CYCLES(0), .ERR_W(4)) dut_fast (
        .clk(clk), .rst(rst), .start(start1),
        .a(a1), .b(b1), .c(c1), .d(d1), .e(e1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .vec_idx(vec1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        n_vec++;
        assert (obs === 32'(expv)) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    // One sweep on the selected instance. n_vecs = vectors visited before
    // done; rst_at >= 0 aborts with a reset at that sample index.
    task automatic run_sweep(input logic s, input int exp_err, input int n_vecs,
                             input bit repulse, input int rst_at);
        int per;
        int k;
        int ev;
        bit got_done;
        res_t r;
        sel = s;
        per = s ? 2 : 6;
        vec_q.delete();
        res_q.delete();
        for (int i = 0; i < n_vecs * per; i++) vec_q.push_back(i / per);
        r.err  = exp_err;
        r.pass = (exp_err == 0) ? 1 : 0;
        r.vec  = n_vecs - 1;
        r.k    = n_vecs * per;
        res_q.push_back(r);

        @(negedge clk); set_start(1'b1);
        @(negedge clk); set_start(1'b0);
        chk("done_clear_on_start", o_done, 0);
        k = 0;
        got_done = 0;
        while (k < 8 * per + 8) begin
            if (o_done) begin
                got_done = 1;
                break;
            end
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_busy", o_busy, 0);
                chk("rst_abc", {o_a, o_b, o_c}, 0);
                chk("rst_err", o_err, 0);
                chk("rst_done", o_done, 0);
                vec_q.delete();
                res_q.delete();
                return;
            end
            ev = (vec_q.size() > 0) ? vec_q.pop_front() : -1;
            chk("vec_idx", o_vec, ev);
            chk("abc", {o_a, o_b, o_c}, ev);
            chk("busy", o_busy, 1);
            set_start(repulse && k == 10);
            @(negedge clk);
            k++;
        end
        set_start(1'b0);
        chk("done_seen", got_done, 1);
        r = res_q.pop_front();
        chk("done_cycle", k, r.k);
        chk("err_count", o_err, r.err);
        chk("pass", o_pass, r.pass);
        chk("final_vec", o_vec, r.vec);
        chk("final_abc", {o_a, o_b, o_c}, r.vec);
        chk("busy_at_done", o_busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy0, 0);
        chk("reset_done", done0, 0);
        chk("reset_pass", pass0, 0);
        chk("reset_err", err0, 0);
        chk("reset_vec", vec0, 0);
        chk("reset_abc", {a0, b0, c0}, 0);
        chk("reset_busy_fast", busy1, 0);

        // Correct gate: full clean sweep.
        run_sweep(1'b0, 0, 8, 1'b0, -1);

        // e stuck at 1: only 111 fails.
        fault_e1 = 1'b1;
        run_sweep(1'b0, 1, 8, 1'b0, -1);
        fault_e1 = 1'b0;

        // d stuck at 0: 000..110 fail.
        fault_d0 = 1'b1;
`ifdef NAND3_SEQ_STOP_ON_ERR_EN
        run_sweep(1'b0, 1, 1, 1'b0, -1);
`else
        run_sweep(1'b0, 7, 8, 1'b0, -1);
`endif
        fault_d0 = 1'b0;

        // start re-pulsed mid-sweep is ignored.
        run_sweep(1'b0, 0, 8, 1'b1, -1);

        // Reset mid-sweep, then a clean sweep.
        run_sweep(1'b0, 0, 8, 1'b0, 20);
        run_sweep(1'b0, 0, 8, 1'b0, -1);

        // Zero settle: two cycles per vector, then restart from DONE.
        run_sweep(1'b1, 0, 8, 1'b0, -1);
        run_sweep(1'b1, 0, 8, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
